pwm_demod: RTL and testbench

Receive-side counterpart of the synthesis PWM output. Recovers the 6-bit sample carried by a 64-tick PWM frame (high for the first N ticks, N = sample value), and queues recovered samples in a small show-ahead FIFO for a bus reader. It sits behind the board-level loopback/test input, clocked by the system `clk`, and uses the same 1 µs tick as the PWM generator.

---
 rtl/pwm_demod.sv | 163 ++++++++++++++++
 tb/tb_pwm_demod.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_demod.sv
// pwm_demod
// Recovers the DW-bit sample carried by each FRAME-tick PWM frame (the input is
// high for the first N ticks, where N is the sample value). Recovered samples go
// into a small show-ahead FIFO that a bus reader drains.
//
// Ports
//   clk       system clock (the only clock)
//   reset     synchronous, active-high
//   tick_i    one-clk strobe at the PWM bit rate; frame logic advances only on it
//   pulse_i   PWM input, asynchronous to clk
//   rd_i      pop the FIFO head (ignored when empty)
//   clr_i     clear the sticky overflow flag
//   data_o    FIFO head sample, 0 when empty (combinational memory read)
//   valid_o   FIFO not empty
//   count_o   FIFO occupancy, 0..DEPTH
//   locked_o  frame alignment confirmed
//   ovf_o     sticky: a sample was dropped because the FIFO was full
module pwm_demod #(
  parameter int FRAME = 64,
  parameter int DW    = 6,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick_i,
  input  logic          pulse_i,
  input  logic          rd_i,
  input  logic          clr_i,
  output logic [DW-1:0] data_o,
  output logic          valid_o,
  output logic [CW-1:0] count_o,
  output logic          locked_o,
  output logic          ovf_o
);

  typedef enum logic {HUNT, TRACK} state_t;

  state_t        state, state_n;
  logic          s1, s, prev;
  logic [DW-1:0] phase, phase_n;
  logic [DW-1:0] hi, hi_n;
  logic          locked_n;
  logic          push;
  logic [DW:0]   hi_sum;
  logic [DW-1:0] hi_sat;
  logic          rise;

  // Two-flop synchronizer; s is the only view of pulse_i the frame logic uses.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= 1'b0;
      s    <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1 <= pulse_i;
      s  <= s1;
      if (tick_i) prev <= s;
    end
  end

  assign rise   = tick_i & s & ~prev;
  // One extra bit so a constantly-high frame (FRAME ticks) clamps to FRAME-1.
  assign hi_sum = {1'b0, hi} + {{DW{1'b0}}, s};
  assign hi_sat = hi_sum[DW] ? {DW{1'b1}} : hi_sum[DW-1:0];

  // ---------------- frame state machine ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= HUNT;
      phase    <= '0;
      hi       <= '0;
      locked_o <= 1'b0;
    end else begin
      state    <= state_n;
      phase    <= phase_n;
      hi       <= hi_n;
      locked_o <= locked_n;
    end
  end

  always_comb begin
    state_n  = state;
    phase_n  = phase;
    hi_n     = hi;
    locked_n = locked_o;
    push     = 1'b0;
    case (state)
      HUNT: begin
        // The edge tick itself is phase 0 and counts as one high tick.
        if (rise) begin
          state_n = TRACK;
          phase_n = DW'(1);
          hi_n    = DW'(1);
        end
      end
      TRACK: begin
        if (tick_i) begin
          if (rise && phase != '0) begin
            // Edge inside a frame: drop the partial frame and realign on it.
            locked_n = 1'b0;
            phase_n  = DW'(1);
            hi_n     = DW'(1);
          end else if (phase == DW'(FRAME - 1)) begin
            push     = 1'b1;
            hi_n     = '0;
            phase_n  = '0;
            locked_n = 1'b1;
          end else begin
            phase_n = phase + DW'(1);
            hi_n    = hi_sat;
          end
        end
      end
      default: state_n = HUNT;
    endcase
  end

  // ---------------- show-ahead FIFO ----------------
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count_n;
  logic          full, pop, wr, ovf_set;

  assign full    = (count_o == CW'(DEPTH));
  assign pop     = rd_i & (count_o != '0);
  // A pop in the same cycle frees the slot the push needs.
  assign wr      = push & (~full | pop);
  assign ovf_set = push & full & ~pop;

  always_comb begin
    count_n = count_o;
    if (wr && !pop)      count_n = count_o + CW'(1);
    else if (pop && !wr) count_n = count_o - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= hi_sat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr    <= '0;
      rptr    <= '0;
      count_o <= '0;
      valid_o <= 1'b0;
      ovf_o   <= 1'b0;
    end else begin
      if (wr)  wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      count_o <= count_n;
      valid_o <= (count_n != '0);
      // Set has priority over a coincident clear.
      if (ovf_set)    ovf_o <= 1'b1;
      else if (clr_i) ovf_o <= 1'b0;
    end
  end

  // Memory contents are not reset, so mask the head while empty.
  assign data_o = valid_o ? mem[rptr] : '0;

endmodule

// File: tb/tb_pwm_demod.sv
// Bench for pwm_demod: drives whole PWM frames tick by tick and compares the
// recovered samples with a frame-level model (expected sample = min(N, 63))
// held in a queue that mimics the FIFO depth and overflow rules.
module tb_pwm_demod;
  localparam int FRAME = 64;
  localparam int DW    = 6;
  localparam int DEPTH = 4;
  localparam int CW    = 3;
  localparam int TDIV  = 10;

  logic          clk = 1'b0;
  logic          reset, tick_i, pulse_i, rd_i, clr_i;
  logic [DW-1:0] data_o;
  logic          valid_o, locked_o, ovf_o;
  logic [CW-1:0] count_o;

  int passed = 0;
  int total  = 0;
  int mq[$];
  bit movf;
  logic [DW-1:0] e;

  pwm_demod #(.FRAME(FRAME), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .tick_i(tick_i), .pulse_i(pulse_i),
    .rd_i(rd_i), .clr_i(clr_i), .data_o(data_o), .valid_o(valid_o),
    .count_o(count_o), .locked_o(locked_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  // Drive one PWM bit period; tick lands TDIV-1 clocks after the pulse level.
  task automatic do_tick(input logic p, input logic rd);
    pulse_i = p;
    repeat (TDIV - 1) @(negedge clk);
    tick_i = 1'b1;
    rd_i   = rd;
    @(negedge clk);
    tick_i = 1'b0;
    rd_i   = 1'b0;
  endtask

  function automatic void model_push(input int n);
    int v;
    v = (n > FRAME - 1) ? FRAME - 1 : n;
    if (mq.size() < DEPTH) mq.push_back(v);
    else movf = 1'b1;
  endfunction

  // n high ticks then low; n >= FRAME means high for the whole frame.
  task automatic send_frame(input int n, input bit rd_last);
    for (int i = 0; i < FRAME; i++) do_tick(i < n, rd_last && (i == FRAME - 1));
    if (rd_last && mq.size() > 0) void'(mq.pop_front());
    model_push(n);
  endtask

  task automatic test_reset();
    reset = 1'b1; tick_i = 1'b0; pulse_i = 1'b0; rd_i = 1'b0; clr_i = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({data_o, valid_o, count_o, locked_o, ovf_o} !== '0)
      $display("FAIL reset_outputs got=%h exp=0", {data_o, valid_o, count_o, locked_o, ovf_o});
    else passed++;
    mq.delete(); movf = 1'b0;
  endtask

  task automatic test_empty_read();
    rd_i = 1'b1; @(negedge clk); rd_i = 1'b0;
    total++;
    if (count_o !== 0 || valid_o !== 1'b0 || data_o !== 0)
      $display("FAIL empty_read count=%0d valid=%0b data=%0d exp 0/0/0", count_o, valid_o, data_o);
    else passed++;
  endtask

  task automatic test_basic();
    send_frame(10, 0);
    total++;
    if (locked_o !== 1'b1 || count_o !== 1)
      $display("FAIL basic_first_lock locked=%0b count=%0d exp 1/1", locked_o, count_o);
    else passed++;
    send_frame(0, 0);
    send_frame(63, 0);
    total++;
    if (count_o !== CW'(mq.size()) || count_o !== 3 || locked_o !== 1'b1)
      $display("FAIL basic_count count=%0d locked=%0b exp 3/1", count_o, locked_o);
    else passed++;
    while (mq.size() > 0) begin
      e = DW'(mq.pop_front());
      total++;
      if (data_o !== e) $display("FAIL basic_pop data=%0d exp=%0d", data_o, e);
      else passed++;
      rd_i = 1'b1; @(negedge clk); rd_i = 1'b0;
    end
    total++;
    if (valid_o !== 1'b0) $display("FAIL basic_drained valid=%0b exp=0", valid_o);
    else passed++;
  endtask

  task automatic test_full_scale();
    send_frame(FRAME, 0);
    send_frame(FRAME, 0);
    send_frame(0, 0);
    send_frame(5, 0);
    total++;
    if (count_o !== 4) $display("FAIL full_scale_count count=%0d exp=4", count_o);
    else passed++;
    while (mq.size() > 0) begin
      e = DW'(mq.pop_front());
      total++;
      if (data_o !== e) $display("FAIL full_scale_pop data=%0d exp=%0d", data_o, e);
      else passed++;
      rd_i = 1'b1; @(negedge clk); rd_i = 1'b0;
    end
  endtask

  task automatic test_overflow();
    for (int n = 1; n <= 6; n++) send_frame(n, 0);
    total++;
    if (count_o !== 4 || ovf_o !== movf || ovf_o !== 1'b1)
      $display("FAIL ovf_set count=%0d ovf=%0b exp 4/1", count_o, ovf_o);
    else passed++;
    while (mq.size() > 0) begin
      e = DW'(mq.pop_front());
      total++;
      if (data_o !== e) $display("FAIL ovf_pop data=%0d exp=%0d", data_o, e);
      else passed++;
      rd_i = 1'b1; @(negedge clk); rd_i = 1'b0;
    end
    clr_i = 1'b1; @(negedge clk); clr_i = 1'b0;
    movf = 1'b0;
    total++;
    if (ovf_o !== 1'b0) $display("FAIL ovf_clear ovf=%0b exp=0", ovf_o);
    else passed++;
    for (int n = 7; n <= 10; n++) send_frame(n, 0);
    send_frame(11, 1);
    total++;
    if (count_o !== 4 || ovf_o !== 1'b0)
      $display("FAIL ovf_push_pop count=%0d ovf=%0b exp 4/0", count_o, ovf_o);
    else passed++;
    while (mq.size() > 0) begin
      e = DW'(mq.pop_front());
      total++;
      if (data_o !== e) $display("FAIL ovf_pop2 data=%0d exp=%0d", data_o, e);
      else passed++;
      rd_i = 1'b1; @(negedge clk); rd_i = 1'b0;
    end
  endtask

  task automatic test_misalign();
    total++;
    if (locked_o !== 1'b1) $display("FAIL misalign_pre locked=%0b exp=1", locked_o);
    else passed++;
    for (int i = 0; i < 20; i++) do_tick(1'b0, 1'b0);
    do_tick(1'b1, 1'b0);   // rising edge at phase 20
    total++;
    if (locked_o !== 1'b0 || count_o !== 0)
      $display("FAIL misalign_unlock locked=%0b count=%0d exp 0/0", locked_o, count_o);
    else passed++;
    for (int i = 0; i < 29; i++) do_tick(1'b1, 1'b0);
    for (int i = 0; i < 33; i++) do_tick(1'b0, 1'b0);
    total++;
    if (locked_o !== 1'b0 || count_o !== 0)
      $display("FAIL misalign_before_end locked=%0b count=%0d exp 0/0", locked_o, count_o);
    else passed++;
    do_tick(1'b0, 1'b0);
    model_push(30);
    total++;
    if (locked_o !== 1'b1 || count_o !== 1 || data_o !== 30)
      $display("FAIL misalign_relock locked=%0b count=%0d data=%0d exp 1/1/30", locked_o, count_o, data_o);
    else passed++;
    send_frame(30, 0);
    while (mq.size() > 0) begin
      e = DW'(mq.pop_front());
      total++;
      if (data_o !== e) $display("FAIL misalign_pop data=%0d exp=%0d", data_o, e);
      else passed++;
      rd_i = 1'b1; @(negedge clk); rd_i = 1'b0;
    end
  endtask

  task automatic test_random();
    int n, npop;
    bit rl;
    for (int f = 0; f < 10; f++) begin
      npop = int'($urandom_range(0, 2));
      for (int k = 0; k < npop; k++) begin
        if (mq.size() > 0) begin
          e = DW'(mq.pop_front());
          total++;
          if (data_o !== e) $display("FAIL rand_pop frame=%0d data=%0d exp=%0d", f, data_o, e);
          else passed++;
        end
        rd_i = 1'b1; @(negedge clk); rd_i = 1'b0;
      end
      n  = int'($urandom_range(0, FRAME));
      rl = 1'($urandom_range(0, 1));
      send_frame(n, rl);
      total++;
      if (count_o !== CW'(mq.size()) || ovf_o !== movf || locked_o !== 1'b1 ||
          data_o !== DW'(mq[0]))
        $display("FAIL rand_frame f=%0d n=%0d count=%0d/%0d ovf=%0b/%0b locked=%0b data=%0d/%0d",
                 f, n, count_o, mq.size(), ovf_o, movf, locked_o, data_o, mq[0]);
      else passed++;
    end
    while (mq.size() > 0) begin
      e = DW'(mq.pop_front());
      total++;
      if (data_o !== e) $display("FAIL rand_drain data=%0d exp=%0d", data_o, e);
      else passed++;
      rd_i = 1'b1; @(negedge clk); rd_i = 1'b0;
    end
    clr_i = 1'b1; @(negedge clk); clr_i = 1'b0;
    movf = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int n = 1; n <= 5; n++) send_frame(n, 0);
    for (int k = 0; k < 2; k++) begin
      void'(mq.pop_front());
      rd_i = 1'b1; @(negedge clk); rd_i = 1'b0;
    end
    total++;
    if (count_o !== 2 || ovf_o !== 1'b1)
      $display("FAIL reset_mid_setup count=%0d ovf=%0b exp 2/1", count_o, ovf_o);
    else passed++;
    for (int i = 0; i < 30; i++) do_tick(i < 5, 1'b0);
    reset = 1'b1; tick_i = 1'b1;
    @(negedge clk);
    reset = 1'b0; tick_i = 1'b0;
    mq.delete(); movf = 1'b0;
    total++;
    if ({data_o, valid_o, count_o, locked_o, ovf_o} !== '0)
      $display("FAIL reset_mid_outputs got=%h exp=0", {data_o, valid_o, count_o, locked_o, ovf_o});
    else passed++;
    for (int i = 0; i < 10; i++) do_tick(1'b0, 1'b0);
    for (int i = 0; i < FRAME - 1; i++) do_tick(i < 7, 1'b0);
    total++;
    if (count_o !== 0 || locked_o !== 1'b0)
      $display("FAIL reset_mid_early count=%0d locked=%0b exp 0/0", count_o, locked_o);
    else passed++;
    do_tick(1'b0, 1'b0);
    model_push(7);
    total++;
    if (count_o !== 1 || data_o !== DW'(mq[0]) || locked_o !== 1'b1)
      $display("FAIL reset_mid_first count=%0d data=%0d locked=%0b exp 1/7/1", count_o, data_o, locked_o);
    else passed++;
  endtask

  task automatic test_tick_in_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) do_tick(1'b1, 1'b0);
    total++;
    if (count_o !== 0 || locked_o !== 1'b0)
      $display("FAIL tick_in_reset_hold count=%0d locked=%0b exp 0/0", count_o, locked_o);
    else passed++;
    reset = 1'b0;
    mq.delete(); movf = 1'b0;
    // Pulse already high: the first tick out of reset must still see a rising edge.
    send_frame(12, 0);
    total++;
    if (count_o !== 1 || data_o !== DW'(mq[0]) || locked_o !== 1'b1)
      $display("FAIL tick_in_reset_frame count=%0d data=%0d locked=%0b exp 1/12/1", count_o, data_o, locked_o);
    else passed++;
  endtask

  initial begin
    reset = 1'b1; tick_i = 1'b0; pulse_i = 1'b0; rd_i = 1'b0; clr_i = 1'b0;
    test_reset();
    test_empty_read();
    test_basic();
    test_full_scale();
    test_overflow();
    test_misalign();
    test_random();
    test_reset_mid();
    test_tick_in_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
